fifo_rd_ctrl: RTL and testbench

FIFO_RD_CTRL -- requirements
Module: fifo_rd_ctrl

---
 rtl/fifo_rd_pkg.sv | 20 ++
 rtl/fifo_rd_skid.sv | 55 +++++
 rtl/fifo_rd_ctrl.sv | 135 +++++++++++++
 tb/tb_fifo_rd_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_rd_pkg.sv
// Shared definitions for the FIFO read-burst controller and its skid buffer.
package fifo_rd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    READ  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam int SKID_DEPTH = 4;
  localparam int SKID_PTR_W = $clog2(SKID_DEPTH);
  localparam int SKID_OCC_W = SKID_PTR_W + 1;

  // A new read may be issued only while buffered plus in-flight words stay at
  // or below this level. That leaves room for the word still on the FIFO q
  // bus, so a stalled sink can never overflow the skid.
  localparam int SKID_ISSUE_LIMIT = 2;

endpackage

// File: rtl/fifo_rd_skid.sv
// Four-entry skid buffer between the FIFO q bus and the downstream stream.
module fifo_rd_skid
  import fifo_rd_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_W-1:0]     push_data,
  input  logic                  pop,
  output logic [DATA_W-1:0]     head,
  output logic                  head_valid,
  output logic [SKID_OCC_W-1:0] occ
);

  logic [DATA_W-1:0]     mem [SKID_DEPTH];
  logic [SKID_PTR_W-1:0] wr_ptr;
  logic [SKID_PTR_W-1:0] rd_ptr;
  logic [SKID_OCC_W-1:0] count;
  logic                  do_push;
  logic                  do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != SKID_OCC_W'(SKID_DEPTH)) || do_pop);

  // Storage array; contents need no reset because the head is masked when empty.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers and occupancy, cleared by reset so buffered words are discarded.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + SKID_PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + SKID_PTR_W'(1);
      end
      count <= count + SKID_OCC_W'(do_push) - SKID_OCC_W'(do_pop);
    end
  end

  assign head_valid = (count != '0);
  assign head       = head_valid ? mem[rd_ptr] : '0;
  assign occ        = count;

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Burst read controller: drains a dual-clock-style FIFO read port into a
// valid/ready stream through a small skid buffer.
//
// state | meaning
// IDLE  | disabled, nothing in progress
// WAIT  | enabled, waiting for the start trigger (rdfull or level threshold)
// READ  | issuing rdreq while the FIFO has data and the skid has room
// DRAIN | no new reads; waiting for in-flight and buffered words to leave
module fifo_rd_ctrl
  import fifo_rd_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int MODE      = 0,
  parameter int THRESH    = 128,
  parameter int BURST_LEN = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] data,
  input  logic              rdfull,
  input  logic              rdempty,
  input  logic [ADDR_W:0]   rdusedw,
  output logic              rdreq,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              busy,
  output logic              burst_done,
  output logic [15:0]       word_cnt
);

  localparam logic [ADDR_W:0] THRESH_LVL = (ADDR_W + 1)'(THRESH);
  localparam logic [15:0]     BURST_MAX  = 16'(BURST_LEN);
  localparam bit              LEN_LIMIT  = (BURST_LEN > 0);

  state_t                state_q;
  state_t                state_d;
  logic                  rd_pend;
  logic [15:0]           burst_cnt;
  logic [SKID_OCC_W-1:0] occ;
  logic [SKID_OCC_W-1:0] pending_words;
  logic                  room;
  logic                  trigger;
  logic                  len_hit;
  logic                  last_req;
  logic                  xfer;

  assign trigger       = (MODE == 0) ? rdfull : (rdusedw >= THRESH_LVL);
  assign pending_words = occ + SKID_OCC_W'(rd_pend);
  assign room          = (pending_words <= SKID_OCC_W'(SKID_ISSUE_LIMIT));
  assign len_hit       = LEN_LIMIT && (burst_cnt >= BURST_MAX);
  assign rdreq         = (state_q == READ) && en && !rdempty && room && !len_hit;
  assign last_req      = LEN_LIMIT && rdreq && (burst_cnt == BURST_MAX - 16'd1);
  assign xfer          = dout_valid && dout_ready;
  assign busy          = (state_q == READ) || (state_q == DRAIN);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode; burst_done marks the DRAIN exit cycle.
  always_comb begin
    state_d    = state_q;
    burst_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (en) state_d = WAIT;
      end
      WAIT: begin
        if (!en)          state_d = IDLE;
        else if (trigger) state_d = READ;
      end
      READ: begin
        if (!en || rdempty || len_hit || last_req) state_d = DRAIN;
      end
      DRAIN: begin
        if (!rd_pend && (occ == '0)) begin
          burst_done = 1'b1;
          state_d    = en ? WAIT : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A read issued this cycle returns data on the next; reset drops it.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_pend <= 1'b0;
    end else begin
      rd_pend <= rdreq;
    end
  end

  // Reads issued in the current burst; restarts while waiting for a trigger.
  always_ff @(posedge clk) begin
    if (rst) begin
      burst_cnt <= '0;
    end else if (state_q == WAIT) begin
      burst_cnt <= '0;
    end else if (rdreq) begin
      burst_cnt <= burst_cnt + 16'd1;
    end
  end

  // Delivered-word counter, free-running and wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      word_cnt <= '0;
    end else if (xfer) begin
      word_cnt <= word_cnt + 16'd1;
    end
  end

  fifo_rd_skid #(
    .DATA_W (DATA_W)
  ) u_skid (
    .clk        (clk),
    .rst        (rst),
    .push       (rd_pend),
    .push_data  (data),
    .pop        (xfer),
    .head       (dout),
    .head_valid (dout_valid),
    .occ        (occ)
  );

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Directed bench: three controller configurations, each fed by a behavioural
// FIFO; a negedge monitor scoreboards every delivered word.
module tb_fifo_rd_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        mrst;
  logic [2:0]  en, rdreq, dout_valid, dout_ready, busy, burst_done, push;
  logic [2:0]  rdfull, rdempty, pop_ok, psh_ok;
  logic [7:0]  dout [3];
  logic [15:0] word_cnt [3];
  logic [8:0]  cnt [3];
  logic [7:0]  q [3];
  logic [7:0]  mem [3][256];
  logic [7:0]  rp [3];
  logic [7:0]  wp [3];
  logic [7:0]  nv [3];

  logic [7:0]  tq [3][16];
  int          th [3] = '{0, 0, 0};
  int          tt [3] = '{0, 0, 0};
  logic [15:0] exp_wc [3] = '{16'd0, 16'd0, 16'd0};
  int          deliv [3] = '{0, 0, 0};
  int          rq_cnt [3] = '{0, 0, 0};
  int          bd_cnt [3] = '{0, 0, 0};
  logic [7:0]  last_out [3];
  logic [2:0]  hold_v = 3'b000;
  logic [7:0]  hold_d [3];

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  fifo_rd_ctrl #(.DATA_W(8), .ADDR_W(8), .MODE(0), .THRESH(128), .BURST_LEN(0)) dut0 (
    .clk(clk), .rst(rst), .en(en[0]), .data(q[0]), .rdfull(rdfull[0]), .rdempty(rdempty[0]),
    .rdusedw(cnt[0]), .rdreq(rdreq[0]), .dout(dout[0]), .dout_valid(dout_valid[0]),
    .dout_ready(dout_ready[0]), .busy(busy[0]), .burst_done(burst_done[0]), .word_cnt(word_cnt[0]));

  fifo_rd_ctrl #(.DATA_W(8), .ADDR_W(8), .MODE(1), .THRESH(16), .BURST_LEN(8)) dut1 (
    .clk(clk), .rst(rst), .en(en[1]), .data(q[1]), .rdfull(rdfull[1]), .rdempty(rdempty[1]),
    .rdusedw(cnt[1]), .rdreq(rdreq[1]), .dout(dout[1]), .dout_valid(dout_valid[1]),
    .dout_ready(dout_ready[1]), .busy(busy[1]), .burst_done(burst_done[1]), .word_cnt(word_cnt[1]));

  fifo_rd_ctrl #(.DATA_W(8), .ADDR_W(8), .MODE(1), .THRESH(4), .BURST_LEN(8)) dut2 (
    .clk(clk), .rst(rst), .en(en[2]), .data(q[2]), .rdfull(rdfull[2]), .rdempty(rdempty[2]),
    .rdusedw(cnt[2]), .rdreq(rdreq[2]), .dout(dout[2]), .dout_valid(dout_valid[2]),
    .dout_ready(dout_ready[2]), .busy(busy[2]), .burst_done(burst_done[2]), .word_cnt(word_cnt[2]));

  for (genvar g = 0; g < 3; g++) begin : g_stat
    assign rdempty[g] = (cnt[g] == 9'd0);
    assign rdfull[g]  = (cnt[g] == 9'd256);
  end
  assign pop_ok = rdreq & ~rdempty;
  assign psh_ok = push & ~rdfull;

  // Behavioural FIFO: 256 deep, q valid one cycle after rdreq, junk otherwise.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (mrst) begin
        rp[i] <= 8'd0; wp[i] <= 8'd0; nv[i] <= 8'd0; cnt[i] <= 9'd0; q[i] <= 8'hA5;
      end else begin
        if (pop_ok[i]) begin
          q[i]  <= mem[i][rp[i]];
          rp[i] <= rp[i] + 8'd1;
        end else begin
          q[i] <= 8'hA5;
        end
        if (psh_ok[i]) begin
          mem[i][wp[i]] <= nv[i];
          wp[i] <= wp[i] + 8'd1;
          nv[i] <= nv[i] + 8'd1;
        end
        cnt[i] <= cnt[i] + 9'(psh_ok[i]) - 9'(pop_ok[i]);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
  endtask

  // Scoreboard: words leave the FIFO into a transit list and must come out in order.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        th[i] = 0; tt[i] = 0; exp_wc[i] = 16'd0; hold_v[i] = 1'b0;
      end else begin
        if (hold_v[i]) begin
          chk("dout_hold", dout[i], hold_d[i]);
          chk("valid_hold", dout_valid[i], 1);
        end
        if (dout_valid[i] && dout_ready[i]) begin
          chk("word_expected", tt[i] > th[i], 1);
          if (tt[i] > th[i]) begin
            chk("word_data", dout[i], tq[i][th[i] % 16]);
            th[i]++;
          end
          exp_wc[i] = exp_wc[i] + 16'd1;
          deliv[i]++;
          last_out[i] = dout[i];
        end
        if (rdreq[i]) begin
          chk("rdreq_when_empty", rdempty[i], 0);
          if (!rdempty[i]) begin
            tq[i][tt[i] % 16] = mem[i][rp[i]];
            tt[i]++;
            rq_cnt[i]++;
            chk("occupancy_bound", (tt[i] - th[i]) <= 5, 1);
          end
        end
        if (burst_done[i]) bd_cnt[i]++;
        hold_v[i] = dout_valid[i] && !dout_ready[i];
        hold_d[i] = dout[i];
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_bd(input int i, input int target, input int limit);
    int n;
    n = 0;
    while (bd_cnt[i] < target && n < limit) begin
      tick(1);
      n++;
    end
    chk("burst_done_count", bd_cnt[i], target);
  endtask

  initial begin
    int n;
    mrst = 1'b1; rst = 1'b1; en = 3'b000; push = 3'b000; dout_ready = 3'b111;
    tick(3);
    mrst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("rst_rdreq", rdreq[i], 0);
      chk("rst_dout_valid", dout_valid[i], 0);
      chk("rst_dout", dout[i], 0);
      chk("rst_busy", busy[i], 0);
      chk("rst_burst_done", burst_done[i], 0);
      chk("rst_word_cnt", word_cnt[i], 0);
    end
    rst = 1'b0;
    tick(1);

    // MODE 1, THRESH 16, BURST_LEN 8: level 20 -> 8 reads, 12 left.
    push[1] = 1'b1; tick(20); push[1] = 1'b0;
    en[1] = 1'b1;
    wait_bd(1, 1, 200);
    chk("b8_rdreq_count", rq_cnt[1], 8);
    chk("b8_delivered", deliv[1], 8);
    chk("b8_last_word", last_out[1], 7);
    chk("b8_fifo_left", cnt[1], 12);
    chk("b8_word_cnt", word_cnt[1], 8);
    push[1] = 1'b1; tick(3); push[1] = 1'b0;
    tick(6);
    chk("below_thresh_busy", busy[1], 0);
    chk("below_thresh_reads", rq_cnt[1], 8);
    push[1] = 1'b1; tick(1); push[1] = 1'b0;
    wait_bd(1, 2, 200);
    chk("thresh_rdreq_count", rq_cnt[1], 16);
    chk("thresh_last_word", last_out[1], 15);
    chk("thresh_fifo_left", cnt[1], 8);
    chk("thresh_word_cnt", word_cnt[1], 16);
    en[1] = 1'b0;

    // BURST_LEN 8 with only 5 words available: short burst.
    push[2] = 1'b1; tick(5); push[2] = 1'b0;
    en[2] = 1'b1;
    wait_bd(2, 1, 100);
    chk("short_rdreq_count", rq_cnt[2], 5);
    chk("short_delivered", deliv[2], 5);
    chk("short_last_word", last_out[2], 4);
    chk("short_fifo_left", cnt[2], 0);
    chk("short_word_cnt", word_cnt[2], 5);
    chk("short_busy", busy[2], 0);
    en[2] = 1'b0;

    // MODE 0, BURST_LEN 0: fill to full, 256 words at one per cycle.
    en[0] = 1'b1;
    push[0] = 1'b1; tick(256); push[0] = 1'b0;
    chk("fill_full", rdfull[0], 1);
    n = 0;
    while (!busy[0] && n < 10) begin tick(1); n++; end
    chk("full_starts_burst", busy[0], 1);
    chk("latency_c0", dout_valid[0], 0);
    tick(1);
    chk("latency_c1", dout_valid[0], 0);
    tick(1);
    chk("latency_c2", dout_valid[0], 1);
    chk("first_word", dout[0], 0);
    tick(256);
    chk("throughput_256", deliv[0], 256);
    wait_bd(0, 1, 20);
    chk("full_rdreq_count", rq_cnt[0], 256);
    chk("full_last_word", last_out[0], 255);
    chk("full_word_cnt", word_cnt[0], 256);
    chk("full_busy_after", busy[0], 0);

    // Random backpressure over 1000 more words.
    push[0] = 1'b1;
    n = 0;
    while (deliv[0] < 1256 && n < 8000) begin
      dout_ready[0] = 1'($urandom_range(0, 1));
      tick(1);
      n++;
    end
    chk("random_reached", deliv[0] >= 1256, 1);
    push[0] = 1'b0; dout_ready[0] = 1'b1;
    wait_bd(0, 2, 2000);
    chk("random_all_delivered", deliv[0], rq_cnt[0]);
    chk("random_word_cnt", word_cnt[0], exp_wc[0]);

    // One-cycle reset in the middle of a burst.
    push[0] = 1'b1;
    n = 0;
    while (!busy[0] && n < 400) begin tick(1); n++; end
    chk("midrst_burst_running", busy[0], 1);
    tick(20);
    rst = 1'b1;
    tick(1);
    chk("midrst_rdreq", rdreq[0], 0);
    chk("midrst_dout_valid", dout_valid[0], 0);
    chk("midrst_dout", dout[0], 0);
    chk("midrst_busy", busy[0], 0);
    chk("midrst_burst_done", burst_done[0], 0);
    chk("midrst_word_cnt", word_cnt[0], 0);
    rst = 1'b0; push[0] = 1'b0;
    tick(1);
    chk("post_rst_valid", dout_valid[0], 0);
    chk("post_rst_dout", dout[0], 0);
    push[0] = 1'b1; tick(1); push[0] = 1'b0;
    wait_bd(0, 3, 600);
    chk("post_rst_word_cnt", word_cnt[0], 256);

    // Stream up to 65535 delivered words, then step through the wrap.
    push[0] = 1'b1;
    n = 0;
    while (exp_wc[0] != 16'hFFFF && n < 70000) begin tick(1); n++; end
    dout_ready[0] = 1'b0;
    chk("wrap_pre", word_cnt[0], 16'hFFFF);
    push[0] = 1'b0;
    tick(2);
    dout_ready[0] = 1'b1; tick(1); dout_ready[0] = 1'b0;
    chk("wrap_zero", word_cnt[0], 0);
    dout_ready[0] = 1'b1; tick(1); dout_ready[0] = 1'b0;
    chk("wrap_one", word_cnt[0], 1);
    en = 3'b000;
    tick(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
